// File: rtl/bus_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_mem_responder_pkg
//   Shared definitions for the 64-bit tagged block bus: beat and tag widths,
//   tag direction encoding, block geometry and the responder state type.
// -----------------------------------------------------------------------------
package bus_mem_responder_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH  = 13;

    // Tag MSB encodes the transfer direction; the remaining bits are an opaque ID.
    localparam logic BUS_TAG_READ  = 1'b1;
    localparam logic BUS_TAG_WRITE = 1'b0;

    // A block is 64 bytes, moved as eight 64-bit beats.
    localparam int BLOCK_BEATS = 8;
    localparam int BEAT_W      = $clog2(BLOCK_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_BURST,
        WRITE_BURST
    } bus_resp_state_t;

endpackage : bus_mem_responder_pkg

// File: rtl/bus_mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// bus_mem_responder_mem_array
//   Single-port word RAM, WORDS x WIDTH. Synchronous write, synchronous read
//   with read enable; rdata holds its last value while re is low.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to addr)
//   re    - read enable (loads rdata from addr)
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
// -----------------------------------------------------------------------------
module bus_mem_responder_mem_array #(
    parameter int WORDS = 4096,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array has no reset; clearing a RAM needs a write
    // sequencer, and it keeps its contents across a reset of the responder.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : bus_mem_responder_mem_array

// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
//   Memory-side endpoint of the tagged block bus. Accepts read/write block
//   requests from one initiator and services them from an internal RAM.
//   Reads return eight beats critical word first after LATENCY cycles;
//   writes absorb eight beats starting at block word 0.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   bus_reqcyc    - request cycle valid (header or write beat)
//   bus_req       - byte address (header) or write data (beat)
//   bus_reqtag    - request tag, MSB = direction (1 read, 0 write)
//   bus_reqack    - request cycle accepted (combinational)
//   bus_respcyc   - response beat valid
//   bus_resp      - response data
//   bus_resptag   - echo of the read header tag
//   bus_respack   - initiator consumes the current response beat
// -----------------------------------------------------------------------------
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = bus_mem_responder_pkg::BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = bus_mem_responder_pkg::BUS_TAG_WIDTH,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    import bus_mem_responder_pkg::*;

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_BEATS - 1);

    bus_resp_state_t           state_q,   state_d;
    logic [AW-1:0]             base_q,    base_d;
    logic [BEAT_W-1:0]         crit_q,    crit_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q,     tag_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]         beat_q,    beat_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q,    resp_d;

    logic                      req_xfer;
    logic                      resp_xfer;
    logic                      hdr_is_read;
    logic [AW-1:0]             hdr_word;
    logic [AW-1:0]             hdr_base;
    logic [BEAT_W-1:0]         hdr_crit;

    logic                      ram_we;
    logic                      ram_re;
    logic [AW-1:0]             ram_addr;
    logic [BEAT_W-1:0]         ram_off;
    logic [BUS_DATA_WIDTH-1:0] ram_rdata;

    // Handshake terms. The request acknowledge is combinational so an idle
    // responder accepts a header in the cycle it is presented.
    assign bus_reqack  = reset_n && bus_reqcyc && (state_q == IDLE || state_q == WRITE_BURST);
    assign req_xfer    = bus_reqcyc && bus_reqack;
    assign bus_respcyc = (state_q == READ_BURST);
    assign resp_xfer   = bus_respcyc && bus_respack;

    // Header decode: word index wraps modulo the RAM depth; the block base has
    // its three beat bits cleared and the critical word is the beat index.
    assign hdr_is_read = (bus_reqtag[BUS_TAG_WIDTH-1] == BUS_TAG_READ);
    assign hdr_word    = AW'(bus_req >> 3);
    assign hdr_base    = hdr_word & ~AW'(BLOCK_BEATS - 1);
    assign hdr_crit    = bus_req[BEAT_W+2:3];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            crit_q    <= '0;
            tag_q     <= '0;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            crit_q    <= crit_d;
            tag_q     <= tag_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            resp_q    <= resp_d;
        end
    end

    // Next-state and datapath register inputs.
    // NOTE: every signal gets its hold value first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        crit_d    = crit_q;
        tag_d     = tag_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        resp_d    = resp_q;

        unique case (state_q)
            IDLE: begin
                if (req_xfer) begin
                    base_d = hdr_base;
                    crit_d = hdr_crit;
                    tag_d  = bus_reqtag;
                    beat_d = '0;
                    if (hdr_is_read) begin
                        state_d   = READ_WAIT;
                        lat_cnt_d = LAT_LOAD;
                    end else begin
                        state_d   = WRITE_BURST;
                    end
                end
            end

            READ_WAIT: begin
                if (lat_cnt_q == '0) begin
                    // The critical word was fetched at header time and has
                    // been held in the RAM output register since.
                    state_d = READ_BURST;
                    beat_d  = '0;
                    resp_d  = ram_rdata;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end

            READ_BURST: begin
                if (resp_xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        resp_d  = '0;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        resp_d  = ram_rdata;
                    end
                end
            end

            WRITE_BURST: begin
                if (req_xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // RAM control. The RAM output register always holds the word that goes
    // onto the bus at the next consumed beat: the critical word is read with
    // the header, word crit+1 in the last wait cycle, and word crit+beat+2
    // whenever a beat is consumed. Offsets wrap inside the block.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_off  = '0;
        ram_addr = base_q;

        unique case (state_q)
            IDLE: begin
                ram_re   = req_xfer && hdr_is_read;
                ram_addr = hdr_base | AW'(hdr_crit);
            end
            READ_WAIT: begin
                ram_re   = (lat_cnt_q == '0);
                ram_off  = crit_q + BEAT_W'(1);
                ram_addr = base_q | AW'(ram_off);
            end
            READ_BURST: begin
                ram_re   = resp_xfer;
                ram_off  = crit_q + beat_q + BEAT_W'(2);
                ram_addr = base_q | AW'(ram_off);
            end
            WRITE_BURST: begin
                ram_we   = req_xfer;
                ram_off  = beat_q;
                ram_addr = base_q | AW'(ram_off);
            end
            default: ;
        endcase
    end

    assign bus_resp    = resp_q;
    assign bus_resptag = bus_respcyc ? tag_q : '0;

    bus_mem_responder_mem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (BUS_DATA_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus_req),
        .rdata (ram_rdata)
    );

endmodule : bus_mem_responder

// File: tb/tb_bus_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_responder
//   Directed bench for bus_mem_responder. Read tasks push the hand-computed
//   beat sequence into a scoreboard queue; a monitor pops and compares on
//   every consumed response beat.
// -----------------------------------------------------------------------------
module tb_bus_mem_responder;

    localparam int DW        = 64;
    localparam int TW        = 13;
    localparam int MEM_WORDS = 4096;
    localparam int LATENCY   = 4;

    typedef logic [DW-1:0] beats_t [8];

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MEM_WORDS),
        .LATENCY        (LATENCY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a beat is consumed at the next rising edge when
    // respcyc and respack are both high; sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus_respcyc && bus_respack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=%h expected=none", bus_resp);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", bus_resp, e.data);
                check("resp_tag", {51'd0, bus_resptag}, {51'd0, e.tag});
            end
        end
    end

    // Presents a header while the responder is idle; it must be accepted in
    // the same cycle. Returns just after the accepting edge.
    task automatic send_header(input logic [63:0] addr, input logic [TW-1:0] tag);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        #1;
        check("hdr_reqack", {63'd0, bus_reqack}, 64'd1);
        @(posedge clk); #1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
    endtask

    task automatic write_block(input logic [63:0] addr, input logic [TW-1:0] tag,
                               input beats_t data, input int gap_after, input int gap_len);
        send_header(addr, tag);
        for (int i = 0; i < 8; i++) begin
            bus_reqcyc = 1'b1;
            bus_req    = data[i];
            #1;
            check("wr_reqack", {63'd0, bus_reqack}, 64'd1);
            @(posedge clk); #1;
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus_reqcyc = 1'b0;
                    bus_req    = '0;
                    #1;
                    check("gap_reqack", {63'd0, bus_reqack}, 64'd0);
                    @(posedge clk); #1;
                end
            end
        end
        bus_reqcyc = 1'b0;
        bus_req    = '0;
    endtask

    // Waits for the first response beat and checks the header-to-beat latency.
    task automatic wait_first_beat();
        int lat = 0;
        while (!bus_respcyc && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("read_latency", lat, LATENCY);
    endtask

    task automatic read_block(input logic [63:0] addr, input logic [TW-1:0] tag,
                              input beats_t exp, input int stall_beat,
                              input int stall_cycles, input logic hold_reqcyc);
        int beat    = 0;
        int stalled = 0;
        int guard   = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back('{data: exp[i], tag: tag});
        bus_respack = 1'b1;
        send_header(addr, tag);
        wait_first_beat();
        while (beat < 8 && guard < 100) begin
            guard++;
            if (beat == stall_beat && stalled < stall_cycles) begin
                bus_respack = 1'b0;
                bus_reqcyc  = hold_reqcyc;
                #1;
                check("stall_data", bus_resp, exp[beat]);
                check("stall_tag", {51'd0, bus_resptag}, {51'd0, tag});
                check("stall_reqack", {63'd0, bus_reqack}, 64'd0);
                stalled++;
                @(posedge clk); #1;
            end else begin
                bus_respack = 1'b1;
                bus_reqcyc  = 1'b0;
                @(posedge clk); #1;
                beat++;
            end
        end
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b1;
        check("burst_end_respcyc", {63'd0, bus_respcyc}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        beats_t v;
        bus_reqcyc  = 1'b1;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reqack", {63'd0, bus_reqack}, 64'd0);
        check("rst_respcyc", {63'd0, bus_respcyc}, 64'd0);
        check("rst_resp", bus_resp, 64'd0);
        check("rst_resptag", {51'd0, bus_resptag}, 64'd0);
        bus_reqcyc = 1'b0;
        reset_n    = 1'b1;
        @(posedge clk); #1;

        // Preload block 0x1000 with 0xA0..0xA7.
        v = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7};
        write_block(64'h1000, 13'h0001, v, -1, 0);

        // Aligned read.
        read_block(64'h1000, 13'h1005, v, -1, 0, 1'b0);

        // Critical-word wrap: 0x1028 -> word 5 first.
        v = '{64'hA5, 64'hA6, 64'hA7, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4};
        read_block(64'h1028, 13'h1006, v, -1, 0, 1'b0);

        // Backpressure on beat 2 for 3 cycles with a request pending.
        v = '{64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7, 64'hA0, 64'hA1};
        read_block(64'h1010, 13'h1ABC, v, 2, 3, 1'b1);

        // Write with a 2-cycle gap after beat 3, then read it back.
        v = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
        write_block(64'h2040, 13'h0003, v, 3, 2);
        read_block(64'h2040, 13'h1003, v, -1, 0, 1'b0);

        // Address wrap: word 0x1000 of a 4096-word RAM aliases word 0.
        v = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
              64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0003,
              64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0005,
              64'hC0DE_0000_0000_0006, 64'hC0DE_0000_0000_0007};
        write_block(64'h8000, 13'h0004, v, -1, 0);
        read_block(64'h0000, 13'h1100, v, -1, 0, 1'b0);

        // Reset in the middle of a read burst after two beats.
        exp_q.push_back('{data: 64'h11, tag: 13'h1001});
        exp_q.push_back('{data: 64'h22, tag: 13'h1001});
        bus_respack = 1'b1;
        send_header(64'h2040, 13'h1001);
        wait_first_beat();
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus_respack = 1'b0;
        bus_reqcyc  = 1'b1;
        reset_n     = 1'b0;
        #1;
        check("midrst_respcyc", {63'd0, bus_respcyc}, 64'd0);
        check("midrst_resp", bus_resp, 64'd0);
        check("midrst_resptag", {51'd0, bus_resptag}, 64'd0);
        check("midrst_reqack", {63'd0, bus_reqack}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        bus_reqcyc  = 1'b0;
        reset_n     = 1'b1;
        bus_respack = 1'b1;
        @(posedge clk); #1;

        // RAM survives reset; a fresh read is accepted right away.
        v = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7};
        read_block(64'h1000, 13'h1007, v, -1, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_mem_responder

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side endpoint of the 64-bit tagged block bus driven by the L1 cache. It accepts read and write requests from a single initiator and services them from an internal word-addressed RAM. Reads return a 64-byte block as eight 64-bit beats, critical word first, after a fixed latency. Writes absorb eight data beats. It serves as the memory model for system simulation and as the bus terminator for the cache.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, beat width; fixed at 64.
- BUS_TAG_WIDTH, 13, tag width; MSB is direction (1 = read, 0 = write), remaining bits are an opaque ID.
- MEM_WORDS, 4096, RAM depth in 64-bit words; power of two, at least 8.
- LATENCY, 4, cycles from read-header acceptance to first response beat; at least 1.

Ports:
- clk, in, 1, single clock; all state changes on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- bus_reqcyc, in, 1, initiator drives a valid header or write beat on bus_req/bus_reqtag.
- bus_req, in, BUS_DATA_WIDTH, byte address in a header cycle; write data in a data cycle.
- bus_reqtag, in, BUS_TAG_WIDTH, request tag; sampled only in the header cycle.
- bus_reqack, out, 1, responder accepts the current request cycle.
- bus_respcyc, out, 1, response beat valid.
- bus_resp, out, BUS_DATA_WIDTH, response data.
- bus_resptag, out, BUS_TAG_WIDTH, echo of the read header tag.
- bus_respack, in, 1, initiator consumes the current response beat.

## Operation
- States: IDLE, READ_WAIT, READ_BURST, WRITE_BURST.
- bus_reqack is combinational: bus_reqcyc && (state == IDLE || state == WRITE_BURST). It is 0 in READ_WAIT and READ_BURST, which backpressures the initiator.
- A request cycle transfers at a rising edge where bus_reqcyc && bus_reqack.
- IDLE with a transfer:
  - Latch base = bus_req[5:0] dropped, crit = bus_req[5:3], and tag.
  - If tag MSB is 1, go to READ_WAIT with lat_cnt = LATENCY-1. If tag MSB is 0, go to WRITE_BURST with beat = 0.
- READ_WAIT: decrement lat_cnt each cycle. At 0, go to READ_BURST with beat = 0 and the first word already registered on bus_resp.
- READ_BURST:
  - bus_respcyc = 1, bus_resptag = latched tag.
  - bus_resp = word at block index (crit + beat) mod 8, so the wrap stays within the block.
  - Outputs hold unchanged while bus_respack = 0.
  - On bus_respcyc && bus_respack, advance beat. After beat 7 is consumed, go to IDLE with bus_respcyc = 0 on the next cycle.
- WRITE_BURST:
  - Each transfer writes bus_req to block word `beat`. Write data always starts at block word 0, ascending; crit is ignored.
  - After beat 7 is written, go to IDLE. Writes produce no response.
- RAM index = (byte address >> 3) mod MEM_WORDS; addresses beyond MEM_WORDS wrap silently.
- A read issued after a completed write to the same block returns the new data.
- Reset:
  - State goes to IDLE. bus_reqack = 0 (bus_reqcyc is ignored while reset_n is low), bus_respcyc = 0, bus_resp = 0, bus_resptag = 0, counters = 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst; a partially written block keeps the beats already written.

## Timing
- Header accepted at edge T. The first response beat is visible in cycle T+LATENCY+1, i.e. bus_respcyc rises after the edge at T+LATENCY.
- With bus_respack held at 1, beats occupy eight consecutive cycles, and the next header is accepted no earlier than the cycle after the last beat.
- Write burst: header plus 8 data transfers, at least 9 cycles. Gaps (bus_reqcyc = 0) are allowed and stall the burst.
- In IDLE, bus_reqack follows bus_reqcyc in the same cycle with zero latency.
- bus_respack while bus_respcyc = 0 is ignored.

## Structure
- Shared bus package holds:
  - BUS_DATA_WIDTH and BUS_TAG_WIDTH.
  - Tag direction constants BUS_TAG_READ = 1 and BUS_TAG_WRITE = 0.
  - The state enum type bus_resp_state_t.
  - BLOCK_BEATS = 8.
- Sub-module mem_array: single-port RAM, MEM_WORDS x 64, synchronous write, synchronous read with read-enable, no reset.
- The responder owns the FSM, the counters, and the output registers. The next read word is fetched one cycle ahead and held while stalled.

## Test plan
- Reset values: assert reset_n = 0 mid-READ_BURST -> all outputs 0 immediately. After release, a read header is accepted with bus_reqack = 1 in the same cycle.
- Aligned read: preload word i of block 0x1000 = 0xA0+i, read header addr 0x1000 tag 0x1005, respack = 1 -> after LATENCY+1 cycles, 8 consecutive beats 0xA0..0xA7, each with resptag 0x1005.
- Critical-word wrap: same block, header addr 0x1028 -> beats 0xA5, 0xA6, 0xA7, 0xA0, ..., 0xA4.
- Backpressure: respack low for 3 cycles on beat 2 -> bus_resp/bus_resptag held stable, no beat skipped or repeated, bus_reqack = 0 throughout.
- Write then read: write header addr 0x2040 tag 0x0003, 8 beats 0x11..0x88 with a 2-cycle reqcyc gap after beat 3 -> reqack only on transfer cycles. A subsequent read of 0x2040 returns 0x11..0x88 in order.
- Address wrap: MEM_WORDS = 4096, write block at 0x8000 -> a read of 0x0000 returns the same data.
